// File: rtl/fpu_job_dispatcher.sv
// fpu_job_dispatcher
//   Buffers job descriptors from the scheduler in a small FIFO, issues them
//   one at a time to the FPU, waits for completion and hands a completion
//   record (id, err) back to the scheduler.
//
// Ports
//   clock, reset_n                 clock, asynchronous active-low reset
//   job_valid/job_ready            scheduler -> FIFO enqueue handshake
//   job_op, job_id, job_a..job_d   job descriptor
//   fpu_start                      one-cycle launch pulse to the FPU
//   fpu_op, fpu_a..fpu_d           descriptor of the job at the FPU
//   fpu_done                       FPU finished the current job
//   cmpl_valid/cmpl_ready          completion record handshake
//   cmpl_id, cmpl_err              tag and error flag of the completed job
//   busy                           FIFO non-empty or a job in flight
//
// Build option
//   FPU_DISPATCH_TIMEOUT_EN : enables a WAIT-state watchdog of TIMEOUT cycles
//                             that completes the job with err=1.
module fpu_job_dispatcher #(
    parameter int DEPTH    = 4,
    parameter int HANDLE_W = 64,
    parameter int ID_W     = 8,
    parameter int TIMEOUT  = 65535
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [5:0]          job_op,
    input  logic [ID_W-1:0]     job_id,
    input  logic [HANDLE_W-1:0] job_a,
    input  logic [HANDLE_W-1:0] job_b,
    input  logic [HANDLE_W-1:0] job_c,
    input  logic [HANDLE_W-1:0] job_d,
    output logic                fpu_start,
    output logic [5:0]          fpu_op,
    output logic [HANDLE_W-1:0] fpu_a,
    output logic [HANDLE_W-1:0] fpu_b,
    output logic [HANDLE_W-1:0] fpu_c,
    output logic [HANDLE_W-1:0] fpu_d,
    input  logic                fpu_done,
    output logic                cmpl_valid,
    input  logic                cmpl_ready,
    output logic [ID_W-1:0]     cmpl_id,
    output logic                cmpl_err,
    output logic                busy
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [5:0]          op;
        logic [ID_W-1:0]     id;
        logic [HANDLE_W-1:0] a;
        logic [HANDLE_W-1:0] b;
        logic [HANDLE_W-1:0] c;
        logic [HANDLE_W-1:0] d;
    } job_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_t;

    // ---------------- FIFO ----------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    job_t             fifo_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             fifo_empty, fifo_full, push, pop;
    job_t             head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign push       = job_valid && !fifo_full;
    assign job_ready  = !fifo_full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= '{op: job_op, id: job_id,
                                                   a: job_a, b: job_b,
                                                   c: job_c, d: job_d};
    end

    // ---------------- control FSM ----------------
    state_t          state_q, state_d;
    job_t            issue_q, issue_d;
    logic            fpu_start_q, fpu_start_d;
    logic            cmpl_valid_q, cmpl_valid_d;
    logic [ID_W-1:0] cmpl_id_q, cmpl_id_d;
    logic            cmpl_err_q, cmpl_err_d;
`ifdef FPU_DISPATCH_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0]     tmo_cnt_q, tmo_cnt_d;
`endif

    // Ops 1..15 go to the FPU; 0 is a NOOP and 16..63 are illegal.
    function automatic logic op_legal(input logic [5:0] op);
        return (op[5:4] == 2'b00) && (op != 6'd0);
    endfunction

    assign pop = (state_q == IDLE) && !fifo_empty;

    always_comb begin
        state_d      = state_q;
        issue_d      = issue_q;
        fpu_start_d  = 1'b0;
        cmpl_valid_d = cmpl_valid_q;
        cmpl_id_d    = cmpl_id_q;
        cmpl_err_d   = cmpl_err_q;
`ifdef FPU_DISPATCH_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: if (!fifo_empty) begin
                issue_d     = head;
                state_d     = ISSUE;
                // Registered so the pulse lines up with the ISSUE cycle.
                fpu_start_d = op_legal(head.op);
            end
            ISSUE: begin
                if (op_legal(issue_q.op)) begin
                    state_d = WAIT;
`ifdef FPU_DISPATCH_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else begin
                    state_d      = REPORT;
                    cmpl_valid_d = 1'b1;
                    cmpl_id_d    = issue_q.id;
                    cmpl_err_d   = (issue_q.op != 6'd0);
                end
            end
            WAIT: begin
                if (fpu_done) begin
                    state_d      = REPORT;
                    cmpl_valid_d = 1'b1;
                    cmpl_id_d    = issue_q.id;
                    cmpl_err_d   = 1'b0;
                end
`ifdef FPU_DISPATCH_TIMEOUT_EN
                // Next count would hit TIMEOUT: give up on the FPU.
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d      = REPORT;
                    cmpl_valid_d = 1'b1;
                    cmpl_id_d    = issue_q.id;
                    cmpl_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
`endif
            end
            REPORT: if (cmpl_ready) begin
                state_d      = IDLE;
                cmpl_valid_d = 1'b0;
                issue_d      = '0;    // FPU sees NOOP/zero handles between jobs
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            issue_q      <= '0;
            fpu_start_q  <= 1'b0;
            cmpl_valid_q <= 1'b0;
            cmpl_id_q    <= '0;
            cmpl_err_q   <= 1'b0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            issue_q      <= issue_d;
            fpu_start_q  <= fpu_start_d;
            cmpl_valid_q <= cmpl_valid_d;
            cmpl_id_q    <= cmpl_id_d;
            cmpl_err_q   <= cmpl_err_d;
`ifdef FPU_DISPATCH_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign fpu_start  = fpu_start_q;
    assign fpu_op     = issue_q.op;
    assign fpu_a      = issue_q.a;
    assign fpu_b      = issue_q.b;
    assign fpu_c      = issue_q.c;
    assign fpu_d      = issue_q.d;
    assign cmpl_valid = cmpl_valid_q;
    assign cmpl_id    = cmpl_id_q;
    assign cmpl_err   = cmpl_err_q;
    assign busy       = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_fpu_job_dispatcher.sv
// Directed bench for fpu_job_dispatcher: a vector table for single jobs plus
// hand-written sequences for full FIFO, completion backpressure, reset during
// WAIT and the WAIT watchdog.
module tb_fpu_job_dispatcher;

    localparam int HW = 64;
    localparam int IW = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          job_valid, job_ready;
    logic [5:0]    job_op;
    logic [IW-1:0] job_id;
    logic [HW-1:0] job_a, job_b, job_c, job_d;
    logic          fpu_start;
    logic [5:0]    fpu_op;
    logic [HW-1:0] fpu_a, fpu_b, fpu_c, fpu_d;
    logic          fpu_done;
    logic          cmpl_valid, cmpl_ready;
    logic [IW-1:0] cmpl_id;
    logic          cmpl_err, busy;

    int total = 0;
    int bad   = 0;

    fpu_job_dispatcher #(.DEPTH(4), .HANDLE_W(HW), .ID_W(IW), .TIMEOUT(20)) dut (
        .clock(clock), .reset_n(reset_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_op(job_op), .job_id(job_id),
        .job_a(job_a), .job_b(job_b), .job_c(job_c), .job_d(job_d),
        .fpu_start(fpu_start), .fpu_op(fpu_op),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_d(fpu_d),
        .fpu_done(fpu_done),
        .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready),
        .cmpl_id(cmpl_id), .cmpl_err(cmpl_err), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]    op;
        logic [IW-1:0] id;
        logic [HW-1:0] a, b, c, d;
        logic          exp_start;
        logic          exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_job(input logic [5:0] op, input logic [IW-1:0] id,
                             input logic [HW-1:0] a, input logic [HW-1:0] b,
                             input logic [HW-1:0] c, input logic [HW-1:0] d);
        job_valid = 1'b1; job_op = op; job_id = id;
        job_a = a; job_b = b; job_c = c; job_d = d;
    endtask

    // Wait (bounded) until fpu_start is seen in the current cycle.
    task automatic wait_start(input string name);
        int n = 0;
        while (fpu_start !== 1'b1 && n < 12) begin
            step();
            n++;
        end
        chk(name, fpu_start, 1'b1);
    endtask

    // Completion handshake in the current cycle, then confirm the record retires.
    task automatic handshake();
        cmpl_ready = 1'b1;
        step();
        cmpl_ready = 1'b0;
        chk("cmpl_retired", cmpl_valid, 1'b0);
    endtask

    // Single job from an empty, idle dispatcher; exact-cycle checks.
    task automatic run_vec(input vec_t v);
        drive_job(v.op, v.id, v.a, v.b, v.c, v.d);  // cycle N
        step();
        job_valid = 1'b0;
        chk("start_n1", fpu_start, 1'b0);            // N+1: pop
        step();
        chk("start_n2", fpu_start, v.exp_start);     // N+2
        if (v.exp_start) begin
            chk("fpu_op", fpu_op, v.op);
            chk("fpu_a", fpu_a, v.a);
            chk("fpu_b", fpu_b, v.b);
            chk("fpu_c", fpu_c, v.c);
            chk("fpu_d", fpu_d, v.d);
            step();
            chk("start_pulse_1cyc", fpu_start, 1'b0);
            repeat (9) step();                        // fpu_start + 10
            chk("no_cmpl_before_done", cmpl_valid, 1'b0);
            fpu_done = 1'b1;
            step();
            fpu_done = 1'b0;
            chk("fpu_d_stable", fpu_d, v.d);
        end else begin
            step();                                   // N+3
            chk("noop_no_start", fpu_start, 1'b0);
        end
        chk("cmpl_valid", cmpl_valid, 1'b1);
        chk("cmpl_id", cmpl_id, v.id);
        chk("cmpl_err", cmpl_err, v.exp_err);
        handshake();
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        vecs[0] = '{op: 6'd1,  id: 8'h11, a: 64'd1, b: 64'd2, c: 64'd3, d: 64'd4, exp_start: 1'b1, exp_err: 1'b0};
        vecs[1] = '{op: 6'd15, id: 8'h12, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'h8000_0000_0000_0001,
                    c: 64'h0123_4567_89AB_CDEF, d: 64'hDEAD_BEEF_0000_0000, exp_start: 1'b1, exp_err: 1'b0};
        vecs[2] = '{op: 6'd0,  id: 8'h20, a: 64'd5, b: 64'd6, c: 64'd7, d: 64'd8, exp_start: 1'b0, exp_err: 1'b0};
        vecs[3] = '{op: 6'd40, id: 8'h21, a: 64'd9, b: 64'd9, c: 64'd9, d: 64'd9, exp_start: 1'b0, exp_err: 1'b1};
        vecs[4] = '{op: 6'd16, id: 8'h22, a: 64'd0, b: 64'd0, c: 64'd0, d: 64'd0, exp_start: 1'b0, exp_err: 1'b1};
        vecs[5] = '{op: 6'd63, id: 8'h23, a: 64'd1, b: 64'd1, c: 64'd1, d: 64'd1, exp_start: 1'b0, exp_err: 1'b1};

        reset_n = 1'b0; job_valid = 1'b0; job_op = '0; job_id = '0;
        job_a = '0; job_b = '0; job_c = '0; job_d = '0;
        fpu_done = 1'b0; cmpl_ready = 1'b0;
        step(); step();
        chk("rst_job_ready", job_ready, 1'b1);
        chk("rst_fpu_start", fpu_start, 1'b0);
        chk("rst_fpu_op", fpu_op, 6'd0);
        chk("rst_fpu_a", fpu_a, 64'd0);
        chk("rst_cmpl_valid", cmpl_valid, 1'b0);
        chk("rst_cmpl_id", cmpl_id, 8'd0);
        chk("rst_cmpl_err", cmpl_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // ---- full FIFO with the FPU stalled ----
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_before_push", job_ready, 1'b1);
            drive_job(6'd1, 8'(i), 64'(i), 64'd0, 64'd0, 64'd0);
            step();
        end
        drive_job(6'd1, 8'd5, 64'd5, 64'd0, 64'd0, 64'd0);   // must be refused
        chk("bp_full_ready", job_ready, 1'b0);
        chk("bp_busy", busy, 1'b1);
        step();
        job_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                wait_start("bp_start");
                chk("bp_fpu_a", fpu_a, 64'(i));
                step();
            end
            fpu_done = 1'b1;
            step();
            fpu_done = 1'b0;
            chk("bp_cmpl_valid", cmpl_valid, 1'b1);
            chk("bp_cmpl_id", cmpl_id, 8'(i));
            handshake();
        end
        step(); step();
        chk("bp_6th_dropped_busy", busy, 1'b0);
        chk("bp_6th_dropped_cmpl", cmpl_valid, 1'b0);

        // ---- completion backpressure with a second job queued ----
        drive_job(6'd2, 8'h30, 64'hA, 64'hB, 64'hC, 64'hD);  // N
        step();
        drive_job(6'd3, 8'h31, 64'h1A, 64'h1B, 64'h1C, 64'h1D);
        step();
        job_valid = 1'b0;
        chk("hold_start0", fpu_start, 1'b1);                 // N+2
        step(); step();
        fpu_done = 1'b1;
        step();
        fpu_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", cmpl_valid, 1'b1);
            chk("hold_id", cmpl_id, 8'h30);
            chk("hold_fpu_op", fpu_op, 6'd2);
            chk("hold_no_start", fpu_start, 1'b0);
            step();
        end
        cmpl_ready = 1'b1;                                   // handshake K
        step();
        cmpl_ready = 1'b0;
        chk("hold_k1_no_start", fpu_start, 1'b0);
        chk("hold_k1_valid", cmpl_valid, 1'b0);
        step();
        chk("hold_k2_start", fpu_start, 1'b1);
        chk("hold_k2_op", fpu_op, 6'd3);
        step();
        fpu_done = 1'b1;
        step();
        fpu_done = 1'b0;
        chk("hold_second_id", cmpl_id, 8'h31);
        handshake();

        // ---- reset while in WAIT ----
        drive_job(6'd1, 8'h40, 64'h77, 64'h77, 64'h77, 64'h77);
        step();
        job_valid = 1'b0;
        wait_start("rst_wait_start");
        step(); step();
        reset_n = 1'b0;
        #1;
        chk("midrst_fpu_op", fpu_op, 6'd0);
        chk("midrst_fpu_a", fpu_a, 64'd0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", job_ready, 1'b1);
        chk("midrst_cmpl_valid", cmpl_valid, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        fpu_done = 1'b1;
        step();
        fpu_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stray_done_no_cmpl", cmpl_valid, 1'b0);
            chk("stray_done_no_start", fpu_start, 1'b0);
            step();
        end

        // ---- watchdog (or indefinite WAIT when the watchdog is not built) ----
        drive_job(6'd4, 8'h50, 64'd1, 64'd2, 64'd3, 64'd4);
        step();
        job_valid = 1'b0;
        wait_start("tmo_start");                             // cycle S
`ifdef FPU_DISPATCH_TIMEOUT_EN
        repeat (20) step();
        chk("tmo_not_yet", cmpl_valid, 1'b0);                // S+20
        step();
        chk("tmo_valid", cmpl_valid, 1'b1);                  // S+21
        chk("tmo_err", cmpl_err, 1'b1);
        chk("tmo_id", cmpl_id, 8'h50);
        handshake();
        fpu_done = 1'b1;
        step();
        fpu_done = 1'b0;
        chk("tmo_stray_done", cmpl_valid, 1'b0);
`else
        repeat (30) step();
        chk("wait_forever_valid", cmpl_valid, 1'b0);
        chk("wait_forever_busy", busy, 1'b1);
        fpu_done = 1'b1;
        step();
        fpu_done = 1'b0;
        chk("late_done_valid", cmpl_valid, 1'b1);
        chk("late_done_err", cmpl_err, 1'b0);
        handshake();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_job_dispatcher.md
# fpu_job_dispatcher

Job-manager-side driver of the FPU job interface: accepts job descriptors (operation code plus four memory handles a, b, c, d) from the scheduler, buffers them in a small FIFO, and issues them one at a time to the FPU. It also tracks each job until the FPU signals completion and reports a completion record back to the scheduler. It sits between the job scheduler and the FPU core and is the sole driver of the FPU's op/handle inputs.

## Interface
- DEPTH, 4: job FIFO entries (power of two, ≥2)
- HANDLE_W, 64: width of one packed memory handle
- ID_W, 8: job tag width
- TIMEOUT, 65535: watchdog limit in cycles (used only with FPU_DISPATCH_TIMEOUT_EN)

Ports:
- clock  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- job_valid  in  1  scheduler offers a job
- job_ready  out  1  FIFO can accept (not full)
- job_op  in  6  op_id code
- job_id  in  ID_W  tag returned on completion
- job_a / job_b / job_c / job_d  in  HANDLE_W each  memory handles
- fpu_start  out  1  one-cycle pulse launching the job on the FPU
- fpu_op  out  6  op driven to FPU
- fpu_a / fpu_b / fpu_c / fpu_d  out  HANDLE_W each  handles driven to FPU
- fpu_done  in  1  one-cycle pulse, FPU finished current job
- cmpl_valid  out  1  completion record valid
- cmpl_ready  in  1  scheduler accepts completion
- cmpl_id  out  ID_W  tag of completed job
- cmpl_err  out  1  job failed (illegal op or timeout)
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Enqueue on job_valid && job_ready; FIFO stores {op, id, a, b, c, d}.
- FSM states: IDLE, ISSUE, WAIT, REPORT.
- IDLE: if FIFO non-empty, pop head into the issue register, then go to ISSUE.
- ISSUE handling:
  - Legal op 1..15: pulse fpu_start for 1 cycle, then go to WAIT.
  - NOOP (0): no fpu_start; go to REPORT with err=0.
  - Op codes 16..63: no fpu_start; go to REPORT with err=1.
- WAIT: on fpu_done, go to REPORT with err=0. fpu_done seen in any other state is ignored.
- REPORT: assert cmpl_valid with id and err. Hold until cmpl_ready; on the handshake, go to IDLE.
- fpu_op and fpu_a..d hold the issue-register value from ISSUE until leaving REPORT. They are stable for the whole job.
- Simultaneous enqueue and pop are both allowed in the same cycle. FIFO full: job_ready=0. The FIFO pointers wrap modulo DEPTH.
- Only one job is outstanding at the FPU at any time.

## Timing
- Reset (async assert, sync release):
  - FSM=IDLE, FIFO empty, job_ready=1.
  - fpu_start=0, fpu_op=0 (NOOP), fpu_a..d=0.
  - cmpl_valid=0, cmpl_id=0, cmpl_err=0, busy=0.
- job_ready depends only on FIFO occupancy. There is no combinational path from job_valid.
- Job enqueued into an empty FIFO in cycle N: pop at N+1 (IDLE), fpu_start high in cycle N+2.
- fpu_done in cycle M: cmpl_valid high from M+1.
- A completion handshake in cycle K lets the next fpu_start occur no earlier than K+2.
- NOOP latency: enqueue at N, cmpl_valid from N+3.
- Reset mid-job: the job is dropped with no completion. Any fpu_done arriving after reset is ignored.

## Configuration
- FPU_DISPATCH_TIMEOUT_EN defined:
  - A 16-bit counter clears on entering WAIT and increments each cycle in WAIT.
  - If it reaches TIMEOUT without fpu_done, the FSM goes to REPORT with err=1.
  - A later stray fpu_done is ignored.
- FPU_DISPATCH_TIMEOUT_EN undefined: no counter, and WAIT waits indefinitely.

## Test plan
- Single job: op=1 (LINEAR_FW), id=0x11, a..d=1,2,3,4. Expect fpu_start 2 cycles after enqueue with fpu_a..d=1,2,3,4. With fpu_done 10 cycles later, expect cmpl_valid next cycle with id=0x11, err=0.
- Backpressure and full FIFO:
  - Push 5 jobs with DEPTH=4 and the FPU stalled: job_ready drops after the 4th enqueue (plus one held in the issue register).
  - Completions return in order with IDs 0..4.
- Special ops: NOOP (id 0x20) gives a completion with err=0 and no fpu_start. Op=40 (id 0x21) gives a completion with err=1 and no fpu_start.
- cmpl_ready held low for 5 cycles: cmpl_valid, cmpl_id and fpu_op stay stable, and no new fpu_start occurs until the handshake.
- Reset asserted during WAIT: all outputs return to reset values immediately. A later fpu_done produces no completion.
- With FPU_DISPATCH_TIMEOUT_EN and TIMEOUT=20, no fpu_done: cmpl_err=1 is reported 21 cycles after fpu_start.
